mem_port_arbiter: RTL and testbench

- Shares the calculator's single-port operand/result memory between two requesters.
- Requester 0 is the calculator controller; requester 1 is the host/debug loader that preloads operands and drains results.
- Issues at most one memory access per cycle and routes read data back to the requester that issued the read.
- Round-robin with bounded burst ownership, so neither side starves.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port operand/result memory, with in-order read routing.
// Optional macro ARB_FIXED_PRIO_EN replaces round-robin/burst ownership with fixed m0 priority.
module mem_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic gnt0, gnt1;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = rst_ni & m0_req_i;
        gnt1 = rst_ni & m1_req_i & ~m0_req_i;
    end
`else
    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e     state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rr_last_q, rr_last_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_last_d   = rr_last_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;

        case (state_q)
            S_OWN0: begin
                if (m0_req_i && ((burst_cnt_q < MaxBurst) || !m1_req_i)) begin
                    gnt0 = 1'b1;
                end else if (m1_req_i) begin
                    gnt1 = 1'b1;
                end
            end
            S_OWN1: begin
                if (m1_req_i && ((burst_cnt_q < MaxBurst) || !m0_req_i)) begin
                    gnt1 = 1'b1;
                end else if (m0_req_i) begin
                    gnt0 = 1'b1;
                end
            end
            default: begin
                if (m0_req_i && m1_req_i) begin
                    gnt0 = rr_last_q;
                    gnt1 = ~rr_last_q;
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
            end
        endcase

        // Grants are masked while reset is held so nothing reaches the memory.
        if (!rst_ni) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            state_d   = S_OWN0;
            rr_last_d = 1'b0;
            if (state_q != S_OWN0) begin
                burst_cnt_d = 4'd1;
            end else if (burst_cnt_q < MaxBurst) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end else if (gnt1) begin
            state_d   = S_OWN1;
            rr_last_d = 1'b1;
            if (state_q != S_OWN1) begin
                burst_cnt_d = 4'd1;
            end else if (burst_cnt_q < MaxBurst) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end else begin
            state_d     = S_IDLE;
            burst_cnt_d = '0;
        end
    end
`endif

    // Memory side: strobes and muxed address/data for the granted requester, zero otherwise.
    always_comb begin
        mem_read_o  = (gnt0 & ~m0_we_i) | (gnt1 & ~m1_we_i);
        mem_write_o = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Read-return tracker: {valid, id} travels RD_LAT stages to line up with mem_rdata_i.
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RD_LAT-1:0] rd_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
            rd_id_q  <= '0;
        end else begin
            rd_vld_q[0] <= mem_read_o;
            rd_id_q[0]  <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_id_q[i]  <= rd_id_q[i-1];
            end
        end
    end

    always_comb begin
        m0_rvalid_o = rd_vld_q[RD_LAT-1] & ~rd_id_q[RD_LAT-1];
        m1_rvalid_o = rd_vld_q[RD_LAT-1] & rd_id_q[RD_LAT-1];
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory environment, behavioural arbitration model and directed vectors.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RD_LAT = 1;
    localparam int MAX_BURST = 4;
    localparam int LOGN = 512;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          mem_read_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h010) return 64'hDEAD_BEEF_0000_0001;
        return 64'hC0DE_0000_0000_0000 | DW'(a);
    endfunction

    // Memory environment seen by the DUT (one-cycle registered read).
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    // Model's own view of memory contents, updated from its predicted grants.
    logic [DW-1:0] shadow  [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = init_word(i);
            shadow[i]  = init_word(i);
        end
    end

    always @(posedge clk_i) begin
        if (mem_write_o) env_mem[mem_addr_o] <= mem_wdata_o;
        if (mem_read_o)  mem_rdata_i <= env_mem[mem_addr_o];
    end

    // Per-cycle log of DUT outputs for the directed literal checks.
    logic          g0_log [0:LOGN-1];
    logic          g1_log [0:LOGN-1];
    logic          rv0_log[0:LOGN-1];
    logic          rv1_log[0:LOGN-1];
    logic          mrd_log[0:LOGN-1];
    logic [AW-1:0] adr_log[0:LOGN-1];
    logic [DW-1:0] rd0_log[0:LOGN-1];
    logic [DW-1:0] rd1_log[0:LOGN-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t pend[$];

    // Arbitration history: who got the previous cycle (-1 = nobody), how many in a row, last winner ever.
    int prev_w = -1;
    int run    = 0;
    int last_w = 1;

    function automatic int pick_winner(input logic r0, input logic r1);
`ifdef ARB_FIXED_PRIO_EN
        if (r0) return 0;
        if (r1) return 1;
        return -1;
`else
        if (r0 && r1) begin
            if (prev_w >= 0) return (run < MAX_BURST) ? prev_w : 1 - prev_w;
            return 1 - last_w;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
`endif
    endfunction

    always @(negedge clk_i) begin
        int            w;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_rv0, e_rv1;
        logic [DW-1:0] e_rd0, e_rd1;
        string         p;
        p = $sformatf("c%0d", cyc);
        if (cyc < LOGN) begin
            g0_log[cyc]  = m0_gnt_o;     g1_log[cyc]  = m1_gnt_o;
            rv0_log[cyc] = m0_rvalid_o;  rv1_log[cyc] = m1_rvalid_o;
            rd0_log[cyc] = m0_rdata_o;   rd1_log[cyc] = m1_rdata_o;
            mrd_log[cyc] = mem_read_o;   adr_log[cyc] = mem_addr_o;
        end
        if (!rst_ni) begin
            chk({p, " reset_outs"},
                {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_read_o, mem_write_o},
                '0);
            chk({p, " reset_buses"}, m0_rdata_o | m1_rdata_o | mem_wdata_o | DW'(mem_addr_o), '0);
            pend.delete();
            prev_w = -1;
            run    = 0;
            last_w = 1;
        end else begin
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].id == 0) begin e_rv0 = 1'b1; e_rd0 = pend[0].data; end
                else                 begin e_rv1 = 1'b1; e_rd1 = pend[0].data; end
                void'(pend.pop_front());
            end
            w = pick_winner(m0_req_i, m1_req_i);
            e_we   = (w == 0) ? m0_we_i   : (w == 1) ? m1_we_i   : 1'b0;
            e_addr = (w == 0) ? m0_addr_i : (w == 1) ? m1_addr_i : '0;
            e_wd   = (w == 0) ? m0_wdata_i : (w == 1) ? m1_wdata_i : '0;
            chk({p, " gnt0"}, m0_gnt_o, w == 0);
            chk({p, " gnt1"}, m1_gnt_o, w == 1);
            chk({p, " mem_read"}, mem_read_o, (w >= 0) && !e_we);
            chk({p, " mem_write"}, mem_write_o, (w >= 0) && e_we);
            chk({p, " mem_addr"}, mem_addr_o, e_addr);
            chk({p, " mem_wdata"}, mem_wdata_o, e_wd);
            chk({p, " rvalid0"}, m0_rvalid_o, e_rv0);
            chk({p, " rdata0"}, m0_rdata_o, e_rd0);
            chk({p, " rvalid1"}, m1_rvalid_o, e_rv1);
            chk({p, " rdata1"}, m1_rdata_o, e_rd1);
            if (w >= 0) begin
                run    = (w == prev_w) ? run + 1 : 1;
                last_w = w;
                if (e_we) shadow[e_addr] = e_wd;
                else      pend.push_back('{due: cyc + RD_LAT, id: w, data: shadow[e_addr]});
            end
            prev_w = w;
        end
        cyc++;
    end

    task automatic drive(input logic r0, input logic we0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic we1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req_i = r0; m0_we_i = we0; m0_addr_i = a0; m0_wdata_i = d0;
        m1_req_i = r1; m1_we_i = we1; m1_addr_i = a1; m1_wdata_i = d1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        int idx, t1, t2, cnt0, cnt1;
        rst_ni = 1'b0;
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        // A held request must not leak through while reset is asserted.
        m0_req_i = 1'b1; m0_addr_i = 10'h010;
        #2;
        chk("rst_gnt0", m0_gnt_o, 1'b0);
        chk("rst_mem_read", mem_read_o, 1'b0);
        m0_req_i = 1'b0; m0_addr_i = '0;
        rst_ni = 1'b1;
        idle(1);

        // Single read of 0x010
        idx = cyc;
        drive(1, 0, 10'h010, '0, 0, 0, '0, '0);
        idle(1);
        chk("single gnt0", g0_log[idx], 1'b1);
        chk("single mem_read", mrd_log[idx], 1'b1);
        chk("single mem_addr", adr_log[idx], 10'h010);
        chk("single rvalid0", rv0_log[idx+1], 1'b1);
        chk("single rdata0", rd0_log[idx+1], 64'hDEAD_BEEF_0000_0001);
        chk("single rvalid1", rv1_log[idx+1], 1'b0);

        // Reset lands on the rvalid cycle of an in-flight read
        idx = cyc;
        drive(1, 0, 10'h010, '0, 0, 0, '0, '0);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rstmid gnt0", g0_log[idx], 1'b1);
        chk("rstmid rvalid0", rv0_log[idx+1], 1'b0);
        chk("rstmid gnt0_held", g0_log[idx+1], 1'b0);
        m0_req_i = 1'b0; m0_addr_i = '0;
        rst_ni = 1'b1;

`ifndef ARB_FIXED_PRIO_EN
        // Continuous contention straight out of reset
        idx = cyc;
        for (int k = 0; k < 12; k++) drive(1, 0, 10'h030, '0, 1, 0, 10'h031, '0);
        idle(2);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("burst k%0d gnt0", k), g0_log[idx+k], ((k / 4) % 2) == 0);
            chk($sformatf("burst k%0d gnt1", k), g1_log[idx+k], ((k / 4) % 2) == 1);
        end

        // Ties from idle, plus write-then-read across requesters
        idx = cyc;
        drive(0, 0, '0, '0, 1, 1, 10'h020, 64'h5);
        idle(2);
        t1 = cyc;
        drive(1, 0, 10'h020, '0, 1, 0, 10'h020, '0);
        idle(1);
        t2 = cyc;
        drive(1, 0, 10'h021, '0, 1, 0, 10'h022, '0);
        idle(2);
        chk("tie write gnt1", g1_log[idx], 1'b1);
        chk("tie1 gnt0", g0_log[t1], 1'b1);
        chk("tie1 gnt1", g1_log[t1], 1'b0);
        chk("tie1 rdata0", rd0_log[t1+1], 64'h5);
        chk("tie2 gnt1", g1_log[t2], 1'b1);
        chk("tie2 gnt0", g0_log[t2], 1'b0);
        chk("tie2 rdata1", rd1_log[t2+1], 64'hC0DE_0000_0000_0022);
`endif

        // Alternating reads routed back to the right requester
        idx = cyc;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive(1, 0, 10'h001, '0, 0, 0, '0, '0);
            else            drive(0, 0, '0, '0, 1, 0, 10'h002, '0);
        end
        idle(2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("route k%0d rv0", k), rv0_log[idx+k+1], (k % 2) == 0);
            chk($sformatf("route k%0d rv1", k), rv1_log[idx+k+1], (k % 2) == 1);
            if (k % 2 == 0) chk($sformatf("route k%0d rd0", k), rd0_log[idx+k+1], 64'hC0DE_0000_0000_0001);
            else            chk($sformatf("route k%0d rd1", k), rd1_log[idx+k+1], 64'hC0DE_0000_0000_0002);
        end

`ifdef ARB_FIXED_PRIO_EN
        idx = cyc;
        for (int k = 0; k < 10; k++) drive(1, 0, 10'h040, '0, 1, 0, 10'h041, '0);
        drive(0, 0, '0, '0, 1, 0, 10'h041, '0);
        idle(2);
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 10; k++) begin
            cnt0 += int'(g0_log[idx+k]);
            cnt1 += int'(g1_log[idx+k]);
        end
        chk("fixed m0 grants", DW'(cnt0), DW'(10));
        chk("fixed m1 grants", DW'(cnt1), DW'(0));
        chk("fixed m1 after drop", g1_log[idx+10], 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
